// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared decode definitions for the control sequencer and execute.
// Holds the opcode/funct/select encodings, the ctrl_word_t layout, the
// sequencer state encoding and CTRL_TABLE, the {opcode, funct} decode function.
// CTRL_TABLE always reports vector encodings as legal. Whether they are
// accepted depends on the CTRL_VECTOR_EN build option in ctrl_sequencer.
package ctrl_pkg;

  localparam int OP_BITS = 5;
  localparam int FN_BITS = 3;

  // Opcodes. R-type and vector-ALU opcodes use funct; all others ignore it.
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00001;
  localparam logic [4:0] OP_LW    = 5'b00010;
  localparam logic [4:0] OP_LH    = 5'b00011;
  localparam logic [4:0] OP_SW    = 5'b00100;
  localparam logic [4:0] OP_SH    = 5'b00101;
  localparam logic [4:0] OP_SUBI  = 5'b00110;
  localparam logic [4:0] OP_JMP   = 5'b01000;
  localparam logic [4:0] OP_JR    = 5'b01001;
  localparam logic [4:0] OP_CALL  = 5'b01010;
  localparam logic [4:0] OP_BE    = 5'b01011;
  localparam logic [4:0] OP_BGT   = 5'b01100;
  localparam logic [4:0] OP_VALU  = 5'b11000;
  localparam logic [4:0] OP_VLDW  = 5'b11001;
  localparam logic [4:0] OP_VLDH  = 5'b11010;
  localparam logic [4:0] OP_VSTW  = 5'b11100;
  localparam logic [4:0] OP_VSTB  = 5'b11101;

  // Funct codes for R-type (scalar) and vector-ALU ops.
  localparam logic [2:0] FN_ADD   = 3'b000;
  localparam logic [2:0] FN_SUB   = 3'b001;
  localparam logic [2:0] FN_MUL   = 3'b010;
  localparam logic [2:0] FN_SLL   = 3'b011;
  localparam logic [2:0] FN_AND   = 3'b100;
  localparam logic [2:0] FN_SRL   = 3'b101;
  localparam logic [2:0] FN_VSUB  = 3'b001;
  localparam logic [2:0] FN_VMUL  = 3'b010;
  localparam logic [2:0] FN_VCSUB = 3'b011;
  localparam logic [2:0] FN_VSR   = 3'b101;

  // ALU operations.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;

  // Operand, branch and jump selects.
  localparam logic [1:0] OPB_REG   = 2'b00;
  localparam logic [1:0] OPB_IMM   = 2'b01;
  localparam logic [1:0] OPB_MEM   = 2'b10;
  localparam logic [1:0] OPB_BYTE  = 2'b11;
  localparam logic [1:0] OPA_REG   = 2'b00;
  localparam logic [1:0] OPA_HALF  = 2'b01;
  localparam logic [1:0] OPA_PC    = 2'b10;
  localparam logic [1:0] OPA_VBASE = 2'b11;
  localparam logic [1:0] BR_EQ     = 2'b01;
  localparam logic [1:0] BR_GT     = 2'b10;
  localparam logic [1:0] JMP_ABS   = 2'b01;
  localparam logic [1:0] JMP_REG   = 2'b10;
  localparam logic [1:0] JMP_CALL  = 2'b11;

  // Sequencer states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_VEC  = 2'd1;
  localparam logic [1:0] ST_MEM  = 2'd2;

  typedef enum logic [1:0] {
    SEQ_IDLE = ST_IDLE,
    SEQ_VEC  = ST_VEC,
    SEQ_MEM  = ST_MEM
  } seq_state_t;

  typedef struct packed {
    logic [1:0] jmp_sel;
    logic       write_register;
    logic       mem_write;
    logic       reg_write;
    logic       vcsub;
    logic [2:0] alu_op;
    logic [1:0] sel_op_b;
    logic       sel_rs2;
    logic [1:0] branch_sel;
    logic [1:0] sel_op_a;
    logic       sel_write_data;
    logic       write_register_vec;
  } ctrl_word_t;

  typedef struct packed {
    ctrl_word_t word;
    logic       is_vec;
    logic       is_mem;
    logic       legal;
  } decode_t;

  // Control fields that an instruction does not use stay 0.
  // An illegal encoding returns all zeros.
  function automatic decode_t CTRL_TABLE(input logic [OP_BITS-1:0] op,
                                         input logic [FN_BITS-1:0] fn);
    decode_t d;
    d = '0;
    d.legal = 1'b1;
    case (op)
      OP_RTYPE: begin
        d.word.write_register = 1'b1;
        d.word.reg_write      = 1'b1;
        case (fn)
          FN_ADD:  d.word.alu_op = ALU_ADD;
          FN_SUB:  d.word.alu_op = ALU_SUB;
          FN_MUL:  d.word.alu_op = ALU_MUL;
          FN_SLL:  d.word.alu_op = ALU_SLL;
          FN_AND:  d.word.alu_op = ALU_AND;
          FN_SRL:  d.word.alu_op = ALU_SRL;
          default: d.legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_SUBI: begin
        d.word.reg_write = 1'b1;
        d.word.sel_op_b  = OPB_IMM;
        d.word.alu_op    = (op == OP_SUBI) ? ALU_SUB : ALU_ADD;
      end
      OP_LW, OP_LH: begin
        d.word.write_register = 1'b1;
        d.word.sel_op_b       = OPB_MEM;
        d.word.sel_rs2        = 1'b1;
        d.word.sel_write_data = (op == OP_LH);
        d.is_mem              = 1'b1;
      end
      OP_SW, OP_SH: begin
        d.word.mem_write = 1'b1;
        d.word.sel_op_b  = OPB_MEM;
        d.word.sel_rs2   = 1'b1;
        d.word.sel_op_a  = (op == OP_SH) ? OPA_HALF : OPA_REG;
        d.is_mem         = 1'b1;
      end
      OP_JMP: d.word.jmp_sel = JMP_ABS;
      OP_JR:  d.word.jmp_sel = JMP_REG;
      OP_CALL: begin
        d.word.jmp_sel        = JMP_CALL;
        d.word.reg_write      = 1'b1;
        d.word.sel_op_a       = OPA_PC;
        d.word.sel_write_data = 1'b1;
      end
      OP_BE, OP_BGT: begin
        d.word.alu_op     = ALU_SUB;
        d.word.branch_sel = (op == OP_BE) ? BR_EQ : BR_GT;
      end
      OP_VALU: begin
        d.word.reg_write          = 1'b1;
        d.word.write_register_vec = 1'b1;
        d.is_vec                  = 1'b1;
        case (fn)
          FN_VSUB:  d.word.alu_op = ALU_SUB;
          FN_VMUL:  d.word.alu_op = ALU_MUL;
          FN_VCSUB: begin
            d.word.alu_op = ALU_SUB;
            d.word.vcsub  = 1'b1;
          end
          FN_VSR:   d.word.alu_op = ALU_SRL;
          default:  d.legal = 1'b0;
        endcase
      end
      OP_VLDW, OP_VLDH: begin
        d.word.write_register_vec = 1'b1;
        d.word.sel_op_b           = OPB_MEM;
        d.word.sel_rs2            = 1'b1;
        d.word.sel_write_data     = (op == OP_VLDH);
        d.is_vec                  = 1'b1;
        d.is_mem                  = 1'b1;
      end
      OP_VSTW, OP_VSTB: begin
        d.word.mem_write = 1'b1;
        d.word.sel_op_b  = (op == OP_VSTB) ? OPB_BYTE : OPB_MEM;
        d.word.sel_op_a  = OPA_VBASE;
        d.is_vec         = 1'b1;
        d.is_mem         = 1'b1;
      end
      default: d.legal = 1'b0;
    endcase
    if (!d.legal) d = '0;
    return d;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational {opcode, funct} decode.
// Ports:
//   opcode, funct   in   instruction fields
//   word            out  decoded control word (all 0 when illegal)
//   is_vec          out  vector instruction
//   is_mem          out  memory instruction
//   legal           out  encoding is present in the control table
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [OP_BITS-1:0] opcode,
  input  logic [FN_BITS-1:0] funct,
  output ctrl_word_t         word,
  output logic               is_vec,
  output logic               is_mem,
  output logic               legal
);

  decode_t d;

  always_comb d = CTRL_TABLE(opcode, funct);

  assign word   = d.word;
  assign is_vec = d.is_vec;
  assign is_mem = d.is_mem;
  assign legal  = d.legal;

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: registered decode and sequencing between fetch and execute.
// Vector ALU ops issue VLEN/LANES beats back to back. Memory ops hold each
// beat until mem_ready arrives.
// Build option: define CTRL_VECTOR_EN to enable vector instructions.
// When CTRL_VECTOR_EN is not defined, the eight vector encodings are treated as
// illegal and beat_idx is tied 0.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   instr_valid/instr_ready, opcode, funct   fetch handshake and fields
//   mem_ready       memory completes the current beat
//   flush           drop the in-flight instruction and any offered one
//   ctl_valid, ctl_word, beat_idx, last_beat  registered control to execute
//   illegal_instr   one-cycle pulse after an undecodable encoding is accepted
//   seq_state       current sequencer state (observation only)
// Handshake: an instruction transfers on a rising edge where
// instr_valid && instr_ready. instr_ready does not depend on instr_valid.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 5,
  parameter int FUNCT_W  = 3,
  parameter int VLEN     = 16,
  parameter int LANES    = 4,
  localparam int BEATS   = VLEN / LANES,
  localparam int BW      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  output logic                instr_ready,
  input  logic                mem_ready,
  input  logic                flush,
  output logic                ctl_valid,
  output logic [17:0]         ctl_word,
  output logic [BW-1:0]       beat_idx,
  output logic                last_beat,
  output logic                illegal_instr,
  output logic [1:0]          seq_state
);

  if ((VLEN % LANES) != 0) begin : g_lanes_check
    $error("ctrl_sequencer: VLEN must be a multiple of LANES");
  end
  if (OPCODE_W != OP_BITS || FUNCT_W != FN_BITS) begin : g_width_check
    $error("ctrl_sequencer: opcode/funct widths must match ctrl_pkg");
  end

  logic [1:0] state;
  ctrl_word_t word_q;
  ctrl_word_t dec_word;
  logic       dec_is_vec;
  logic       dec_is_mem;
  logic       dec_legal;
  logic       issue_legal;
  logic       finishing;
  logic       accept;

  ctrl_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .word   (dec_word),
    .is_vec (dec_is_vec),
    .is_mem (dec_is_mem),
    .legal  (dec_legal)
  );

`ifdef CTRL_VECTOR_EN
  localparam logic [BW-1:0] LAST_IDX = BW'(BEATS - 1);
  logic [BW-1:0] beat;
  logic [BW-1:0] beat_next;
  logic          vec_q;
  logic          on_last;

  assign beat_next   = beat + 1'b1;
  assign on_last     = (beat == LAST_IDX);
  assign issue_legal = dec_legal;
  assign beat_idx    = beat;
`else
  // Vector encodings decode, but they are rejected here as illegal.
  assign issue_legal = dec_legal && !dec_is_vec;
  assign beat_idx    = '0;
`endif

  // finishing: the current cycle ends the instruction in flight, or there is
  // no instruction in flight. A new instruction can be accepted in the same
  // cycle, so issue continues without a bubble.
  always_comb begin
    finishing = 1'b1;
    case (state)
`ifdef CTRL_VECTOR_EN
      ST_VEC:  finishing = on_last;
      ST_MEM:  finishing = mem_ready && (!vec_q || on_last);
`else
      ST_MEM:  finishing = mem_ready;
`endif
      default: finishing = 1'b1;
    endcase
  end

  assign instr_ready = finishing && !flush && !rst;
  assign accept      = instr_valid && instr_ready;
  assign ctl_word    = word_q;
  assign seq_state   = state;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state         <= ST_IDLE;
      ctl_valid     <= 1'b0;
      word_q        <= '0;
      last_beat     <= 1'b0;
      illegal_instr <= 1'b0;
`ifdef CTRL_VECTOR_EN
      beat          <= '0;
      vec_q         <= 1'b0;
`endif
    end else begin
      illegal_instr <= 1'b0;
      if (finishing) begin
        if (accept && issue_legal) begin
          ctl_valid <= 1'b1;
          word_q    <= dec_word;
`ifdef CTRL_VECTOR_EN
          beat      <= '0;
          vec_q     <= dec_is_vec;
          if (dec_is_mem) begin
            state     <= ST_MEM;
            last_beat <= !dec_is_vec || (BEATS == 1);
          end else if (dec_is_vec && (BEATS > 1)) begin
            state     <= ST_VEC;
            last_beat <= 1'b0;
          end else begin
            state     <= ST_IDLE;
            last_beat <= 1'b1;
          end
`else
          state     <= dec_is_mem ? ST_MEM : ST_IDLE;
          last_beat <= 1'b1;
`endif
        end else begin
          // Nothing to issue, or an illegal encoding was accepted. An illegal
          // encoding produces a pulse and does not stall.
          state         <= ST_IDLE;
          ctl_valid     <= 1'b0;
          word_q        <= '0;
          last_beat     <= 1'b0;
          illegal_instr <= accept;
`ifdef CTRL_VECTOR_EN
          beat          <= '0;
`endif
        end
      end else begin
`ifdef CTRL_VECTOR_EN
        // Mid-instruction: VEC advances every cycle. MEM advances only on
        // mem_ready, and here mem_ready can only mean a non-final beat.
        if (state == ST_VEC || mem_ready) begin
          beat      <= beat_next;
          last_beat <= (beat_next == LAST_IDX);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed steps followed by random stimulus. Outputs are
// compared each cycle against a beat-queue reference model.
module tb_ctrl_sequencer;
  import ctrl_pkg::*;

  localparam int VLEN  = 16;
  localparam int LANES = 4;
  localparam int BEATS = VLEN / LANES;
`ifdef CTRL_VECTOR_EN
  localparam bit VEC_EN = 1'b1;
`else
  localparam bit VEC_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        instr_valid;
  logic [4:0]  opcode;
  logic [2:0]  funct;
  logic        instr_ready;
  logic        mem_ready;
  logic        flush;
  logic        ctl_valid;
  logic [17:0] ctl_word;
  logic [1:0]  beat_idx;
  logic        last_beat;
  logic        illegal_instr;
  logic [1:0]  seq_state;

  ctrl_sequencer #(.OPCODE_W(5), .FUNCT_W(3), .VLEN(VLEN), .LANES(LANES)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .opcode        (opcode),
    .funct         (funct),
    .instr_ready   (instr_ready),
    .mem_ready     (mem_ready),
    .flush         (flush),
    .ctl_valid     (ctl_valid),
    .ctl_word      (ctl_word),
    .beat_idx      (beat_idx),
    .last_beat     (last_beat),
    .illegal_instr (illegal_instr),
    .seq_state     (seq_state)
  );

  // ---------------- reference ISA table ----------------
  // kind: 0 scalar, 1 scalar memory, 2 vector ALU, 3 vector memory
  logic [4:0]  t_op   [25];
  logic [2:0]  t_fn   [25];
  logic        t_care [25];
  int          t_kind [25];
  logic [17:0] t_word [25];

  task automatic add(input int i, input logic [4:0] op, input logic [2:0] fn,
                     input logic care, input int kind, input logic [17:0] w);
    t_op[i] = op; t_fn[i] = fn; t_care[i] = care; t_kind[i] = kind; t_word[i] = w;
  endtask

  task automatic init_table();
    //            op        fn      care kind  jm wr mw rw vc alu  ob r2 br oa wd wv
    add(0,  5'b00000, 3'b000, 1, 0, 18'b00_1_0_1_0_000_00_0_00_00_0_0); // ADD
    add(1,  5'b00000, 3'b001, 1, 0, 18'b00_1_0_1_0_001_00_0_00_00_0_0); // SUB
    add(2,  5'b00000, 3'b010, 1, 0, 18'b00_1_0_1_0_010_00_0_00_00_0_0); // MUL
    add(3,  5'b00000, 3'b011, 1, 0, 18'b00_1_0_1_0_011_00_0_00_00_0_0); // SLL
    add(4,  5'b00000, 3'b100, 1, 0, 18'b00_1_0_1_0_100_00_0_00_00_0_0); // AND
    add(5,  5'b00000, 3'b101, 1, 0, 18'b00_1_0_1_0_101_00_0_00_00_0_0); // SRL
    add(6,  5'b00001, 3'b000, 0, 0, 18'b00_0_0_1_0_000_01_0_00_00_0_0); // ADDI
    add(7,  5'b00110, 3'b000, 0, 0, 18'b00_0_0_1_0_001_01_0_00_00_0_0); // SUBI
    add(8,  5'b00010, 3'b000, 0, 1, 18'b00_1_0_0_0_000_10_1_00_00_0_0); // LW
    add(9,  5'b00011, 3'b000, 0, 1, 18'b00_1_0_0_0_000_10_1_00_00_1_0); // LH
    add(10, 5'b00100, 3'b000, 0, 1, 18'b00_0_1_0_0_000_10_1_00_00_0_0); // SW
    add(11, 5'b00101, 3'b000, 0, 1, 18'b00_0_1_0_0_000_10_1_00_01_0_0); // SH
    add(12, 5'b01000, 3'b000, 0, 0, 18'b01_0_0_0_0_000_00_0_00_00_0_0); // JMP
    add(13, 5'b01001, 3'b000, 0, 0, 18'b10_0_0_0_0_000_00_0_00_00_0_0); // JR
    add(14, 5'b01010, 3'b000, 0, 0, 18'b11_0_0_1_0_000_00_0_00_10_1_0); // CALL
    add(15, 5'b01011, 3'b000, 0, 0, 18'b00_0_0_0_0_001_00_0_01_00_0_0); // BE
    add(16, 5'b01100, 3'b000, 0, 0, 18'b00_0_0_0_0_001_00_0_10_00_0_0); // BGT
    add(17, 5'b11000, 3'b001, 1, 2, 18'b00_0_0_1_0_001_00_0_00_00_0_1); // VSUB
    add(18, 5'b11000, 3'b010, 1, 2, 18'b00_0_0_1_0_010_00_0_00_00_0_1); // VMUL
    add(19, 5'b11000, 3'b011, 1, 2, 18'b00_0_0_1_1_001_00_0_00_00_0_1); // VCSUB
    add(20, 5'b11000, 3'b101, 1, 2, 18'b00_0_0_1_0_101_00_0_00_00_0_1); // VSR
    add(21, 5'b11001, 3'b000, 0, 3, 18'b00_0_0_0_0_000_10_1_00_00_0_1); // VLDW
    add(22, 5'b11010, 3'b000, 0, 3, 18'b00_0_0_0_0_000_10_1_00_00_1_1); // VLDH
    add(23, 5'b11100, 3'b000, 0, 3, 18'b00_0_1_0_0_000_10_0_00_11_0_0); // VSTW
    add(24, 5'b11101, 3'b000, 0, 3, 18'b00_0_1_0_0_000_11_0_00_11_0_0); // VSTB
  endtask

  function automatic int lookup(input logic [4:0] op, input logic [2:0] fn);
    for (int i = 0; i < 25; i++)
      if (t_op[i] == op && (!t_care[i] || t_fn[i] == fn)) return i;
    return -1;
  endfunction

  // ---------------- scoreboard ----------------
  // One entry per outstanding beat: {waits_for_mem, beat_idx, ctl_word}.
  logic [20:0] exp_q[$];
  logic        exp_ill = 1'b0;
  logic        check_idle = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input logic v, input logic [4:0] op, input logic [2:0] fn,
                      input logic mr, input logic fl, input logic r);
    logic [20:0] f;
    logic        ev, el, done, er;
    logic [17:0] ew;
    logic [1:0]  ei;
    int          k, n;
    instr_valid = v; opcode = op; funct = fn; mem_ready = mr; flush = fl; rst = r;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      f = exp_q[0];
      ev = 1'b1; ew = f[17:0]; ei = f[19:18];
      el = (exp_q.size() == 1);
      done = !f[20] || mr;
    end else begin
      ev = 1'b0; ew = '0; ei = '0; el = 1'b0; done = 1'b0;
    end
    er = !fl && !r && (exp_q.size() == 0 || (exp_q.size() == 1 && done));
    chk("ctl_valid", ctl_valid, ev);
    chk("ctl_word", ctl_word, ew);
    chk("beat_idx", beat_idx, ei);
    chk("last_beat", last_beat, el);
    chk("illegal_instr", illegal_instr, exp_ill);
    chk("instr_ready", instr_ready, er);
    if (check_idle) begin
      chk("state_idle", seq_state, ST_IDLE);
      check_idle = 1'b0;
    end
    @(posedge clk);
    if (r || fl) begin
      exp_q.delete();
      exp_ill = 1'b0;
    end else begin
      if (done) void'(exp_q.pop_front());
      exp_ill = 1'b0;
      if (v && er) begin
        k = lookup(op, fn);
        if (k < 0 || (!VEC_EN && t_kind[k] >= 2)) exp_ill = 1'b1;
        else begin
          n = (t_kind[k] >= 2) ? BEATS : 1;
          for (int i = 0; i < n; i++)
            exp_q.push_back({(t_kind[k] == 1 || t_kind[k] == 3), 2'(i), t_word[k]});
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'b0, 3'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    logic [4:0] rop;
    logic [2:0] rfn;
    init_table();
    rst = 1'b1; instr_valid = 1'b0; opcode = '0; funct = '0; mem_ready = 1'b0; flush = 1'b0;
    @(posedge clk); #1;

    // reset state, including mem_ready ignored under reset
    step(1'b0, 5'b0, 3'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'b00000, 3'b000, 1'b1, 1'b0, 1'b1);

    // ADD, then idle
    step(1'b1, 5'b00000, 3'b000, 1'b0, 1'b0, 1'b0);
    idle(1);

    // VMUL, with ADD offered until it is taken on the last beat
    step(1'b1, 5'b11000, 3'b010, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 5'b00000, 3'b000, 1'b0, 1'b0, 1'b0);
    idle(2);

    // LW: mem_ready low 3 cycles, then high
    step(1'b1, 5'b00010, 3'b000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 5'b0, 3'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'b0, 3'b0, 1'b1, 1'b0, 1'b0);
    idle(1);

    // VSTW with mem_ready every other cycle
    step(1'b1, 5'b11100, 3'b000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 5'b0, 3'b0, 1'((i % 2) == 1), 1'b0, 1'b0);
    idle(1);

    // flush at beat 1 of VSUB while ADD is offered
    step(1'b1, 5'b11000, 3'b001, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'b0, 3'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'b00000, 3'b000, 1'b1, 1'b1, 1'b0);
    check_idle = 1'b1;
    idle(2);

    // illegal encoding, then back-to-back JMP
    step(1'b1, 5'b00111, 3'b000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'b01000, 3'b000, 1'b0, 1'b0, 1'b0);
    idle(1);

    // reset in the middle of a vector load
    step(1'b1, 5'b11001, 3'b000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'b0, 3'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 5'b00000, 3'b000, 1'b1, 1'b0, 1'b1);
    check_idle = 1'b1;
    idle(2);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 4) == 0) begin
        rop = 5'($urandom_range(0, 31));
        rfn = 3'($urandom_range(0, 7));
      end else begin
        k = $urandom_range(0, 24);
        rop = t_op[k];
        rfn = t_care[k] ? t_fn[k] : 3'($urandom_range(0, 7));
      end
      step(1'($urandom_range(0, 3) != 0), rop, rfn, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 99) == 0));
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Registered, multi-cycle successor to the combinational ISA decoder. It decodes `{opcode, funct}` into the 18-bit control word and sequences it over time. Vector ops are split into `VLEN/LANES` beats, and memory ops are held until the memory handshake completes. It sits between fetch and execute: it drives `instr_ready` back-pressure to fetch and supplies a registered control word plus beat index to the datapath.

## Interface
- `OPCODE_W`, 5, opcode width
- `FUNCT_W`, 3, ALU function field width
- `VLEN`, 16, elements per vector register
- `LANES`, 4, datapath lanes; `VLEN % LANES == 0` is required, checked by elaboration assertion
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `instr_valid`  in  1  fetch presents an instruction
- `opcode`  in  OPCODE_W  instruction opcode
- `funct`  in  FUNCT_W  ALU function field
- `instr_ready`  out  1  instruction accepted when `instr_valid && instr_ready`
- `mem_ready`  in  1  memory completes the current beat
- `flush`  in  1  discard in-flight instruction (branch/jump redirect)
- `ctl_valid`  out  1  control word valid this cycle
- `ctl_word`  out  18  `{jmp_sel[1:0], write_register, mem_write, reg_write, vcsub, alu_op[2:0], sel_op_b[1:0], sel_rs2, branch_sel[1:0], sel_op_a[1:0], sel_write_data, write_register_vec}`
- `beat_idx`  out  $clog2(VLEN/LANES) (min 1)  current beat
- `last_beat`  out  1  final beat of the instruction
- `illegal_instr`  out  1  one-cycle pulse for an undecodable encoding

## Operation
- **States:**
  - IDLE: no instruction in flight
  - VEC: multi-beat vector ALU op
  - MEM: waiting on memory
- **Decode:** the ISA control table in `ctrl_pkg` covers 25 encodings: ADD, ADDI, SUB, SUBI, MUL, SLL, AND, SRL, LW, LH, SW, SH, JMP, JR, CALL, BE, BGT, VMUL, VSR, VSUB, VCSUB, VLDW, VLDH, VSTW, VSTB. Table don't-care bits are driven 0.
- **Scalar non-memory op (ALU, jump, branch):** issued for one cycle with `last_beat=1`. State stays IDLE.
- **Scalar memory op (LW/LH/SW/SH):**
  - Go to MEM and hold `ctl_word` with `ctl_valid=1` until `mem_ready`.
  - That cycle is the last beat; then return to IDLE.
- **Vector ALU op (VMUL/VSR/VSUB/VCSUB):**
  - Go to VEC and issue BEATS = `VLEN/LANES` consecutive cycles, `beat_idx` 0..BEATS-1.
  - `ctl_word` is constant across beats.
- **Vector memory op (VLDW/VLDH/VSTW/VSTB):**
  - Go to MEM. Each beat holds until `mem_ready`, then `beat_idx` increments.
  - The final beat completes on `mem_ready` at `beat_idx == BEATS-1`.
- **`instr_ready`** is 1 when any of these holds, and is forced 0 when `flush` or `rst`:
  - state is IDLE, or
  - state is VEC and `beat_idx == BEATS-1`, or
  - state is MEM, on the final beat, and `mem_ready=1`.

  This gives back-to-back issue with no bubble.
- **Illegal encoding:**
  - Accepted normally, then next cycle `illegal_instr=1`, `ctl_valid=0`, `ctl_word=0`. State stays IDLE.
  - Illegal encodings never stall.
- **`flush`:**
  - Next cycle: state IDLE, `ctl_valid=0`, `beat_idx=0`, outputs 0.
  - A `flush` coinciding with `instr_valid` does not accept the instruction.
  - A `flush` coinciding with `mem_ready` drops the beat.
- **`rst` mid-operation:** same effect as `flush`, plus `instr_ready=0` while `rst` is high.

## Timing
- Accept at edge N → `ctl_valid`/`ctl_word`/`beat_idx`/`last_beat` registered, visible in cycle N+1.
- Vector ALU op: beats in cycles N+1..N+BEATS.
- Reset values: `ctl_valid=0`, `ctl_word=0`, `beat_idx=0`, `last_beat=0`, `illegal_instr=0`, state IDLE.
- `instr_ready`:
  - 0 during reset, 1 from the first cycle after `rst` deasserts.
  - Combinational from state, `beat_idx`, `mem_ready`, `flush`.
- `mem_ready` while `ctl_valid=0` is ignored.
- BEATS=1 (`VLEN==LANES`): vector ALU ops behave as scalar ops, with `last_beat=1` on every issue.

## Configuration
- `CTRL_VECTOR_EN` defined: vector encodings decode and sequence as described.
- Not defined:
  - All eight vector encodings are illegal (illegal pulse, no stall).
  - The VEC state and vector branches of MEM are removed.
  - `beat_idx` is tied 0.

## Structure
- `ctrl_pkg` holds the following, shared with execute:
  - opcode/funct localparams
  - the `ctrl_word_t` packed struct (field order as in `ctl_word`)
  - the `CTRL_TABLE` decode function
  - the `seq_state_t` enum
- One sub-module, `ctrl_decode`: purely combinational `{opcode,funct}` → `{ctrl_word_t, is_vec, is_mem, legal}`. The FSM, counter and output registers live in `ctrl_sequencer`.

## Test plan
- Reset, then ADD (`00000/000`) at cycle 1 → cycle 2: `ctl_valid=1`, `ctl_word=18'b001010000000000000`, `last_beat=1`, `instr_ready` stays 1.
- VMUL (`11000/010`), VLEN=16, LANES=4 → four valid cycles, `beat_idx` 0,1,2,3, `last_beat` only on 3. `instr_ready` is 0 for beats 0–2 and 1 on beat 3, and an ADD presented then issues the next cycle.
- LW (`00010/000`) with `mem_ready` low 3 cycles then high → `ctl_word=18'b001000000101000000` held 4 cycles, then IDLE. `instr_ready` is 1 only in the `mem_ready` cycle.
- VSTW (`11100/000`) with `mem_ready` pulsed every other cycle → `beat_idx` advances only on `mem_ready`, completing after 4 pulses.
- `flush` asserted at `beat_idx=1` of VSUB, simultaneous with `instr_valid` → next cycle `ctl_valid=0`, state IDLE, instruction not accepted.
- Encoding `00111/000` → one `illegal_instr` pulse, `ctl_valid=0`. Also, with `CTRL_VECTOR_EN` undefined, VMUL → illegal pulse, no stall.
